mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, memory address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0/req1  input  1  level access request, held until grant.
REQ-006 SHALL have ports wr0/wr1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  access address; stable while req high.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data; stable while req high.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse; access is performed in this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse; read data valid.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  read data, meaningful only with rvalid.
REQ-012 SHALL have port clr_start  input  1  level request to zero the whole memory.
REQ-013 SHALL have port busy  output  1  high while any access or clear is in progress.
REQ-014 SHALL have port clr_done  output  1  one-cycle pulse when a clear completes.
REQ-015 SHALL have ports mem_wr/mem_addr/mem_din  output  1/ADDR_W/DATA_W  memory write enable, address, write data.
REQ-016 SHALL have port mem_dout  input  DATA_W  memory read data; synchronous read, valid the cycle after the read cycle, holds value during writes.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, CLEAR.
REQ-018 In IDLE with clr_start high, SHALL go to CLEAR with clear counter = 0; clr_start has priority over req0/req1.
REQ-019 In IDLE with a req and no clr_start, SHALL go to ACCESS and register the owner: sole requester wins; if both requesters are high, the one that is not last_owner wins.
REQ-020 In ACCESS, SHALL drive mem_wr = owner wr, mem_addr = owner addr, mem_din = owner wdata, and pulse gnt of the owner only; it SHALL update last_owner and return to IDLE next cycle (maximum one access per 2 cycles).
REQ-021 For a read access, SHALL pulse the owner's rvalid in the cycle after ACCESS, with rdata = mem_dout in that cycle; the non-owner's rvalid stays 0.
REQ-022 In CLEAR, SHALL drive mem_wr = 1, mem_addr = counter, mem_din = 0, and increment the counter each cycle; after writing address 2^ADDR_W-1, it SHALL return to IDLE and pulse clr_done in the following cycle.
REQ-023 Requests arriving during CLEAR or ACCESS SHALL be held off (no gnt) and arbitrated on the next IDLE cycle.
REQ-024 Outside ACCESS and CLEAR, SHALL hold mem_wr = 0, mem_addr = 0, mem_din = 0.
REQ-025 busy SHALL be high in ACCESS, in CLEAR, and in the rvalid cycle.
REQ-026 A clear SHALL take exactly 2^ADDR_W cycles in CLEAR; counter wrap SHALL not start a second pass.

Reset
REQ-027 While reset is low, SHALL force state IDLE, last_owner = 1 (requester 0 wins the first tie), counter = 0, and all outputs 0.
REQ-028 Reset asserted mid-CLEAR or mid-ACCESS SHALL abandon the operation with no clr_done, gnt or rvalid afterward.

Structure
REQ-029 FSM state encoding, ADDR_W/DATA_W defaults and the owner encoding SHALL live in shared package mem_arb_pkg.
REQ-030 The round-robin winner select SHALL be sub-module rr_pick2 (inputs req0, req1, last_owner; output winner, any).
REQ-031 The memory itself SHALL stay external; mem_arbiter contains no storage array.

Verification
REQ-032 Idle after reset, req0 with wr0=1, addr0=5, wdata0=0xA5 -> gnt0 pulses 2 cycles after req; mem_wr=1, mem_addr=5, mem_din=0xA5 in that cycle.
REQ-033 req1 with wr1=0, addr1=5 after scenario 1 -> gnt1, then rvalid1=1 with rdata1=0xA5 the next cycle; rvalid0 stays 0.
REQ-034 req0 and req1 held high together for 8 cycles -> gnt sequence 0,1,0,1, one grant every 2 cycles.
REQ-035 clr_start and req0 both high in IDLE -> 64 cycles with mem_wr=1, mem_addr 0..63, mem_din=0; clr_done pulses; gnt0 follows; a read of address 5 then returns 0x00.
REQ-036 reset driven low at clear address 20 -> outputs 0 immediately; after release, no clr_done; FSM in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_CLEAR} state_e;
  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_e;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic any
);
  assign any    = req0 | req1;
  assign winner = (req0 & req1) ? ~last_owner : req1;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one external synchronous-read memory, with a full-memory clear.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_e            state_q, state_d;
  owner_e            owner_q, last_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rd_pend_q, clr_done_q;
  logic              win, any;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_owner(last_q == OWN1),
    .winner    (win),
    .any       (any)
  );

  assign own_wr    = (owner_q == OWN1) ? wr1    : wr0;
  assign own_addr  = (owner_q == OWN1) ? addr1  : addr0;
  assign own_wdata = (owner_q == OWN1) ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (clr_start) state_d = ST_CLEAR;
                 else if (any)  state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      ST_CLEAR:  if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // owner_q stays put through the read-return cycle so rvalid steers to the right port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN0;
      last_q     <= OWN1;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rd_pend_q  <= (state_q == ST_ACCESS) && !own_wr;
      clr_done_q <= (state_q == ST_CLEAR) && (cnt_q == CNT_LAST);
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!clr_start && any) owner_q <= owner_e'(win);
        end
        ST_ACCESS: last_q <= owner_q;
        ST_CLEAR:  cnt_q  <= cnt_q + 1'b1;
        default:   cnt_q  <= '0;
      endcase
    end
  end

  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        mem_wr   = own_wr;
        mem_addr = own_addr;
        mem_din  = own_wdata;
        gnt0     = (owner_q == OWN0);
        gnt1     = (owner_q == OWN1);
      end
      ST_CLEAR: begin
        mem_wr   = 1'b1;
        mem_addr = cnt_q;
      end
      default: ;
    endcase
    rvalid0  = rd_pend_q && (owner_q == OWN0);
    rvalid1  = rd_pend_q && (owner_q == OWN1);
    rdata0   = rvalid0 ? mem_dout : '0;
    rdata1   = rvalid1 ? mem_dout : '0;
    busy     = (state_q != ST_IDLE) || rd_pend_q;
    clr_done = clr_done_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a grant/read-return scoreboard.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, clr_start = 0;
  logic [5:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, clr_done, mem_wr;
  logic [7:0] rdata0, rdata1, mem_din;
  logic [7:0] mem_dout = 8'h00;
  logic [5:0] mem_addr;
  logic [7:0] mem [64];

  typedef struct packed {
    logic       is_rd;
    logic       port;
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // synchronous-read memory: output register holds during write cycles
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    else        mem_dout      <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && (gnt0 | gnt1 | rvalid0 | rvalid1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {60'd0, gnt0, gnt1, rvalid0, rvalid1}, 64'd0);
      end else begin
        e = sb.pop_front();
        if (!e.is_rd)
          chk("grant", {47'd0, gnt0, gnt1, mem_wr, mem_addr, mem_din},
              {47'd0, !e.port, e.port, e.wr, e.addr, e.data});
        else
          chk("rvalid", {46'd0, rvalid0, rvalid1, rdata0, rdata1},
              {46'd0, !e.port, e.port, (e.port ? 8'h00 : e.data), (e.port ? e.data : 8'h00)});
      end
    end
  end

  task automatic wait_gnt(output int n);
    n = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_sb();
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int   n;
    logic found, seen;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {27'd0, gnt0, gnt1, rvalid0, rvalid1, busy, clr_done, mem_wr,
                          mem_addr, mem_din, rdata0, rdata1}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // write 0xA5 to address 5 from port 0
    @(posedge clk); #1;
    req0 = 1; wr0 = 1; addr0 = 6'd5; wdata0 = 8'hA5;
    sb.push_back({1'b0, 1'b0, 1'b1, 6'd5, 8'hA5});
    wait_gnt(n);
    chk("gnt_latency", 64'(n), 64'd2);
    @(posedge clk); #1 req0 = 0; wr0 = 0;
    wait_sb();

    // read it back from port 1
    @(posedge clk); #1;
    req1 = 1; wr1 = 0; addr1 = 6'd5; wdata1 = 8'h00;
    sb.push_back({1'b0, 1'b1, 1'b0, 6'd5, 8'h00});
    sb.push_back({1'b1, 1'b1, 1'b0, 6'd0, 8'hA5});
    wait_gnt(n);
    chk("gnt1_seen", 64'(n < 99), 64'd1);
    @(posedge clk); #1 req1 = 0;
    wait_sb();

    // both held for 8 cycles: alternate 0,1,0,1
    @(posedge clk); #1;
    req0 = 1; wr0 = 1; addr0 = 6'd10; wdata0 = 8'h11;
    req1 = 1; wr1 = 1; addr1 = 6'd20; wdata1 = 8'h22;
    for (int k = 0; k < 2; k++) begin
      sb.push_back({1'b0, 1'b0, 1'b1, 6'd10, 8'h11});
      sb.push_back({1'b0, 1'b1, 1'b1, 6'd20, 8'h22});
    end
    repeat (8) @(posedge clk);
    #1 req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    wait_sb();

    // clear wins over a simultaneous request; the request is served afterwards
    @(posedge clk); #1;
    clr_start = 1; req0 = 1; wr0 = 0; addr0 = 6'd5; wdata0 = 8'h00;
    @(posedge clk); #1 clr_start = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("clear_cycle", {47'd0, gnt0, gnt1, mem_wr, mem_addr, mem_din, busy},
          {47'd0, 1'b0, 1'b0, 1'b1, 6'(i), 8'h00, 1'b1});
    end
    sb.push_back({1'b0, 1'b0, 1'b0, 6'd5, 8'h00});
    sb.push_back({1'b1, 1'b0, 1'b0, 6'd0, 8'h00});
    @(negedge clk);
    chk("clr_done", {62'd0, clr_done, mem_wr}, 64'd2);
    @(posedge clk); #1 req0 = 0;
    @(negedge clk);
    chk("clr_done_pulse", {63'd0, clr_done}, 64'd0);
    wait_sb();

    // reset during clear at address 20
    @(posedge clk); #1 clr_start = 1;
    @(posedge clk); #1 clr_start = 0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_wr && mem_addr == 6'd20) begin
        found = 1;
        break;
      end
    end
    chk("reach_addr20", {63'd0, found}, 64'd1);
    reset = 1'b0;
    #1;
    chk("reset_mid_clear", {44'd0, gnt0, gnt1, rvalid0, rvalid1, busy, clr_done, mem_wr,
                            mem_addr, mem_din}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (clr_done | busy | mem_wr) seen = 1;
    end
    chk("no_done_after_reset", {63'd0, seen}, 64'd0);

    // first tie after reset goes to port 0
    @(posedge clk); #1;
    req0 = 1; wr0 = 1; addr0 = 6'd1; wdata0 = 8'h33;
    req1 = 1; wr1 = 1; addr1 = 6'd2; wdata1 = 8'h44;
    sb.push_back({1'b0, 1'b0, 1'b1, 6'd1, 8'h33});
    wait_gnt(n);
    chk("tie_gnt_seen", 64'(n < 99), 64'd1);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    wait_sb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
